// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter joining an instruction-fetch port and a
// data port onto one memory request port, with a bounded wait per access.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ifReq/ifAddr        fetch request (read only), held until ifValid
//   ifValid/ifRdata     one-cycle fetch completion and read word
//   dReq/dWe/dAddr      data request, write flag, address
//   dWdata/dBe          write data and byte enables
//   dValid/dRdata       one-cycle data completion and read word
//   err                 completion ended in a timeout (with ifValid/dValid)
//   memReq/memWe        memory request and write enable
//   memAddr/memWdata    memory address and write data
//   memBe               memory byte enables
//   memReady/memRdata   memory done, read data valid in the same cycle
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifValid,
    output logic [DATA_W-1:0] ifRdata,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    input  logic [3:0]        dBe,
    output logic              dValid,
    output logic [DATA_W-1:0] dRdata,
    output logic              err,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    output logic [3:0]        memBe,
    input  logic              memReady,
    input  logic [DATA_W-1:0] memRdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IBUSY,
        S_DBUSY,
        S_DONE
    } state_t;

    localparam logic [7:0] C_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic       r_lastGntD;   // 1: data port was granted most recently
    logic [7:0] r_cnt;

    logic w_busy;
    logic w_gntI;
    logic w_gntD;
    logic w_tout;
    logic w_fin;

    assign w_busy = (r_state == S_IBUSY) || (r_state == S_DBUSY);
    // On a tie the fetch port wins only if data went last.
    assign w_gntI = (r_state == S_IDLE) && ifReq && (!dReq || r_lastGntD);
    assign w_gntD = (r_state == S_IDLE) && dReq && !w_gntI;
    // A late memReady in the final wait cycle still completes normally.
    assign w_tout = w_busy && !memReady && (r_cnt == C_LAST);
    assign w_fin  = w_busy && (memReady || w_tout);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_gntI) begin
                    w_next = S_IBUSY;
                end else if (w_gntD) begin
                    w_next = S_DBUSY;
                end
            end
            S_IBUSY, S_DBUSY: begin
                if (w_fin) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Registered outputs, wait counter and round-robin flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memWdata   <= '0;
            memBe      <= 4'h0;
            ifValid    <= 1'b0;
            dValid     <= 1'b0;
            err        <= 1'b0;
            ifRdata    <= '0;
            dRdata     <= '0;
            r_cnt      <= 8'd0;
            r_lastGntD <= 1'b1;
        end else begin
            ifValid <= 1'b0;
            dValid  <= 1'b0;
            err     <= 1'b0;
            if (w_gntI) begin
                memReq     <= 1'b1;
                memWe      <= 1'b0;
                memAddr    <= ifAddr;
                memBe      <= 4'hF;
                r_cnt      <= 8'd0;
                r_lastGntD <= 1'b0;
            end else if (w_gntD) begin
                memReq     <= 1'b1;
                memWe      <= dWe;
                memAddr    <= dAddr;
                memWdata   <= dWdata;
                memBe      <= dBe;
                r_cnt      <= 8'd0;
                r_lastGntD <= 1'b1;
            end else if (w_fin) begin
                memReq <= 1'b0;
                err    <= !memReady;
                if (r_state == S_IBUSY) begin
                    ifValid <= 1'b1;
                    ifRdata <= memReady ? memRdata : '0;
                end else begin
                    dValid <= 1'b1;
                    // Writes and timeouts return zero read data.
                    dRdata <= (memReady && !memWe) ? memRdata : '0;
                end
            end else if (w_busy) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have these parameters: ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 15, max cycles memReq waits for memReady (range 2..255).
REQ-002 The block SHALL have these ports:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-high reset
  ifReq  in  1  fetch request (read only), level, held until ifValid
  ifAddr  in  ADDR_W  fetch address
  ifValid  out  1  one-cycle fetch completion
  ifRdata  out  DATA_W  fetched word, valid with ifValid
  dReq  in  1  data request, level, held until dValid
  dWe  in  1  1 = write, 0 = read
  dAddr  in  ADDR_W  data address
  dWdata  in  DATA_W  write data
  dBe  in  4  byte enables
  dValid  out  1  one-cycle data completion
  dRdata  out  DATA_W  read data, valid with dValid
  err  out  1  completion was a timeout, valid with ifValid/dValid
  memReq  out  1  unified memory request
  memWe  out  1  memory write enable
  memAddr  out  ADDR_W  memory address
  memWdata  out  DATA_W  memory write data
  memBe  out  4  memory byte enables
  memReady  in  1  memory done; memRdata valid the same cycle
  memRdata  in  DATA_W  memory read data

Function
REQ-003 The block SHALL implement FSM states IDLE, IBUSY, DBUSY, DONE; all outputs registered.
REQ-004 In IDLE with only ifReq high, the block SHALL latch ifAddr, set memWe=0, memBe=4'hF and enter IBUSY at that edge.
REQ-005 In IDLE with only dReq high, the block SHALL latch dAddr/dWe/dWdata/dBe onto the mem* outputs and enter DBUSY.
REQ-006 With ifReq and dReq both high in IDLE, the block SHALL grant the requester not granted last (round-robin via lastGnt flag; lastGnt updates on every grant).
REQ-007 memReq SHALL be high exactly during IBUSY/DBUSY, with memAddr/memWe/memWdata/memBe stable throughout.
REQ-008 When memReady is sampled high in IBUSY/DBUSY, the block SHALL register memRdata into ifRdata (IBUSY) or dRdata (DBUSY, reads only; writes load 0), pulse the matching valid, keep err=0 and enter DONE.
REQ-009 A wait counter SHALL clear on each grant and increment every BUSY cycle without memReady.
REQ-010 When the counter reaches TIMEOUT-1 and memReady is low, the block SHALL drop memReq, load rdata=0, pulse the matching valid with err=1 and enter DONE.
REQ-011 memReady high in the timeout cycle SHALL complete normally (err=0).
REQ-012 DONE SHALL last one cycle, during which valid/err are high and requests are ignored, then return to IDLE.
REQ-013 Requesters SHALL drop req during the DONE cycle; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-014 Minimum latency: req sampled at edge N -> memReq cycle N+1 -> with memReady in that cycle, valid high in cycle N+2, IDLE at N+3.
REQ-015 memReady in IDLE or DONE SHALL be ignored.
REQ-016 ifValid and dValid SHALL never be high in the same cycle.

Reset
REQ-017 On rst high, the block SHALL immediately force state=IDLE, memReq=0, memWe=0, memAddr=0, memWdata=0, memBe=0, ifValid=0, dValid=0, err=0, ifRdata=0, dRdata=0, counter=0, lastGnt=data.
REQ-018 Reset mid-transaction SHALL abandon it with no completion pulse; the first request after release SHALL be arbitrated fresh (fetch wins a tie).

Verification
REQ-019 Fetch read: ifReq=1, ifAddr=0x100, memReady=1 in the first memReq cycle, memRdata=0x002080B3 -> memWe=0, memBe=F, ifValid one cycle with ifRdata=0x002080B3, err=0, latency per REQ-014.
REQ-020 Data write: dReq=1, dWe=1, dAddr=0x204, dWdata=0xDEADBEEF, dBe=4'b0011, memReady after 3 wait cycles -> memReq high 4 cycles with stable fields, dValid one pulse, dRdata=0.
REQ-021 Contention: ifReq and dReq both high from reset release, each held until served -> fetch granted first, data second, no overlapping memReq, then strict alternation over 4 further transactions.
REQ-022 Timeout: dReq read, memReady never asserted -> memReq high exactly 15 cycles, then dValid=1, err=1, dRdata=0, IDLE two cycles later.
REQ-023 Boundary: memReady first asserted in cycle 15 -> normal completion, err=0, memRdata captured.
REQ-024 Reset mid-op: rst pulsed during DBUSY cycle 2 -> memReq falls asynchronously, no dValid, next ifReq served normally.
